// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    localparam int NB_MASTERS      = 2;
    localparam int DEFAULT_TIMEOUT = 256;

endpackage

// File: rtl/wshb_if.sv
// Wishbone link bundle: master drives cyc/stb/we/adr/sel/dat_ms,
// slave answers with ack/err/rty/dat_sm.
interface wshb_if;

    logic [31:0] dat_ms;
    logic [31:0] dat_sm;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic        cyc;
    logic        stb;
    logic        we;
    logic        ack;
    logic        err;
    logic        rty;

    modport master (
        output cyc, stb, we, adr, sel, dat_ms,
        input  ack, err, rty, dat_sm
    );

    modport slave (
        input  cyc, stb, we, adr, sel, dat_ms,
        output ack, err, rty, dat_sm
    );

endinterface

// File: rtl/wb_arb_watchdog.sv
// Stall watchdog for the arbiter: counts consecutive strobed cycles that
// got no ack/err/rty and flags the cycle in which the count reaches
// TIMEOUT-1. Only instantiated when WB_ARB_TIMEOUT_EN is defined.
module wb_arb_watchdog #(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic done,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] wd_cnt;

    // Expiry depends only on the count so the forced-low strobe cannot
    // loop back through the slave's combinational ack.
    assign expired = active && (wd_cnt == LAST);

    // Count stalled strobe cycles; any response, idle strobe or expiry restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (!active || done || expired) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/wb_arbiter_2m.sv
// Two-master, one-slave Wishbone arbiter with round-robin grant held for a
// whole cyc bus cycle. Optional stall watchdog enabled by WB_ARB_TIMEOUT_EN,
// which also adds the TIMEOUT parameter.
module wb_arbiter_2m
    import wb_arb_pkg::*;
`ifdef WB_ARB_TIMEOUT_EN
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
)
`endif
(
    input  logic                  clk,
    input  logic                  rst_n,
    wshb_if.slave                 wb_s0,
    wshb_if.slave                 wb_s1,
    wshb_if.master                wb_m,
    output logic [NB_MASTERS-1:0] gnt
);

    arb_state_t state;
    arb_state_t state_nxt;
    logic       last;
    logic       last_nxt;
    logic       grant0;
    logic       grant1;
    logic       req_stb;
    logic       wd_expired;

    assign grant0  = (state == GNT0);
    assign grant1  = (state == GNT1);
    assign gnt     = {grant1, grant0};
    assign req_stb = (grant0 & wb_s0.cyc & wb_s0.stb) | (grant1 & wb_s1.cyc & wb_s1.stb);

`ifdef WB_ARB_TIMEOUT_EN
    logic wd_done;

    assign wd_done = wb_m.ack | wb_m.err | wb_m.rty;

    wb_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .active  (req_stb),
        .done    (wd_done),
        .expired (wd_expired)
    );
`else
    assign wd_expired = 1'b0;
`endif

    // Next grant: ties go to the master that was not served last; an owner
    // keeps the bus until it drops cyc or the watchdog aborts the cycle.
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (wb_s0.cyc && wb_s1.cyc) begin
                    if (last) begin
                        state_nxt = GNT0;
                        last_nxt  = 1'b0;
                    end else begin
                        state_nxt = GNT1;
                        last_nxt  = 1'b1;
                    end
                end else if (wb_s0.cyc) begin
                    state_nxt = GNT0;
                    last_nxt  = 1'b0;
                end else if (wb_s1.cyc) begin
                    state_nxt = GNT1;
                    last_nxt  = 1'b1;
                end
            end
            GNT0: begin
                if (!wb_s0.cyc || wd_expired) begin
                    state_nxt = IDLE;
                end
            end
            GNT1: begin
                if (!wb_s1.cyc || wd_expired) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grant state and round-robin memory; reset releases the bus at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
        end
    end

    // Forward the owner's request to the slave; idle bus is all zeros.
    always_comb begin
        wb_m.cyc    = 1'b0;
        wb_m.we     = 1'b0;
        wb_m.adr    = '0;
        wb_m.sel    = '0;
        wb_m.dat_ms = '0;
        if (grant0) begin
            wb_m.cyc    = wb_s0.cyc;
            wb_m.we     = wb_s0.we;
            wb_m.adr    = wb_s0.adr;
            wb_m.sel    = wb_s0.sel;
            wb_m.dat_ms = wb_s0.dat_ms;
        end else if (grant1) begin
            wb_m.cyc    = wb_s1.cyc;
            wb_m.we     = wb_s1.we;
            wb_m.adr    = wb_s1.adr;
            wb_m.sel    = wb_s1.sel;
            wb_m.dat_ms = wb_s1.dat_ms;
        end
        wb_m.stb = req_stb & ~wd_expired;
    end

    // Return the slave's response to the owner only while it still holds
    // cyc, so a late ack after an abandoned cycle reaches nobody.
    always_comb begin
        wb_s0.ack    = grant0 & wb_s0.cyc & wb_m.ack;
        wb_s0.err    = grant0 & wb_s0.cyc & (wb_m.err | wd_expired);
        wb_s0.rty    = grant0 & wb_s0.cyc & wb_m.rty;
        wb_s0.dat_sm = grant0 ? wb_m.dat_sm : '0;
        wb_s1.ack    = grant1 & wb_s1.cyc & wb_m.ack;
        wb_s1.err    = grant1 & wb_s1.cyc & (wb_m.err | wd_expired);
        wb_s1.rty    = grant1 & wb_s1.cyc & wb_m.rty;
        wb_s1.dat_sm = grant1 ? wb_m.dat_sm : '0;
    end

endmodule
